// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared pipeline constants for the writeback stage.
//   - Bit offsets of each field inside the 107-bit MEM/WB bundle. The bundle
//     is numbered ascending, so bit 0 is the MSB of nextPC.
//   - Load size encodings carried in the DSize field.
//   - The index of the hardwired zero register.
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  // MEM/WB bundle field offsets (first bit of each field, ascending numbering)
  localparam int OFF_NEXTPC   = 0;
  localparam int OFF_DESTREG  = 32;
  localparam int OFF_ALU      = 37;
  localparam int OFF_DATAOUT  = 69;
  localparam int OFF_PCTOREG  = 101;
  localparam int OFF_REGWRITE = 102;
  localparam int OFF_MEMTOREG = 103;
  localparam int OFF_LOADSIGN = 104;
  localparam int OFF_DSIZE    = 105;

  localparam int BUNDLE_WIDTH = 107;

  // Load size encodings
  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  // Hardwired zero register
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Extracts a byte, halfword or word from a big-endian memory word and
//   sign- or zero-extends it to 32 bits.
//   Ports:
//     dataOut     in  32  full word read from the word-aligned address
//     byteOffset  in  2   low address bits; 0 selects the most significant byte
//     dSize       in  2   access size (byte / half / word)
//     loadSign    in  1   1 = sign-extend byte and halfword loads
//     alignedData out 32  value to be written back
// ---------------------------------------------------------------------------
module load_align
  import wb_regfile_pkg::*;
(
  input  logic [31:0] dataOut,
  input  logic [1:0]  byteOffset,
  input  logic [1:0]  dSize,
  input  logic        loadSign,
  output logic [31:0] alignedData
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  // Big-endian lane selection: offset 0 is the top byte of the word, and
  // halfwords only look at the upper offset bit (misaligned low bit ignored).
  always_comb begin
    selByte = dataOut[31:24];
    case (byteOffset)
      2'd0:    selByte = dataOut[31:24];
      2'd1:    selByte = dataOut[23:16];
      2'd2:    selByte = dataOut[15:8];
      default: selByte = dataOut[7:0];
    endcase
    selHalf = byteOffset[1] ? dataOut[15:0] : dataOut[31:16];
  end

  // Extension by size; both word encodings pass the word through untouched.
  always_comb begin
    alignedData = dataOut;
    case (dSize)
      DSIZE_BYTE: alignedData = {{24{loadSign & selByte[7]}}, selByte};
      DSIZE_HALF: alignedData = {{16{loadSign & selHalf[15]}}, selHalf};
      default:    alignedData = dataOut;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback stage plus 32 x 32-bit integer register file. Picks the
//   writeback value from the MEM/WB bundle, commits it on the rising edge,
//   and serves two combinational decode read ports with write-through bypass.
//   r0 is hardwired to zero.
//   Ports:
//     clk       in  1          pipeline clock
//     reset     in  1          asynchronous, active-low reset
//     wb_in     in  [0:106]    MEM/WB bundle (bit 0 = MSB)
//     rs1_addr  in  [0:4]      read port A index
//     rs2_addr  in  [0:4]      read port B index
//     rs1_data  out [0:31]     read port A data
//     rs2_data  out [0:31]     read port B data
//     wb_we     out 1          effective write enable (for forwarding)
//     wb_reg    out [0:4]      destination index
//     wb_data   out [0:31]     value being written
// ---------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int WIDTH = BUNDLE_WIDTH,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] wb_in,
  input  logic [0:4]       rs1_addr,
  input  logic [0:4]       rs2_addr,
  output logic [0:31]      rs1_data,
  output logic [0:31]      rs2_data,
  output logic             wb_we,
  output logic [0:4]       wb_reg,
  output logic [0:31]      wb_data
);

  logic [31:0] nextPc;
  logic [4:0]  destReg;
  logic [31:0] aluResult;
  logic [31:0] dataOut;
  logic        pcToReg;
  logic        regWrite;
  logic        memToReg;
  logic        loadSign;
  logic [1:0]  dSize;

  logic [31:0] alignedData;
  logic [31:0] wbValue;
  logic        writeEn;

  logic [31:0] regFile [NREG];

  // Unpack the bundle. Ascending slices land MSB-first in the descending
  // internal vectors, so numeric values are preserved.
  assign nextPc    = wb_in[OFF_NEXTPC   +: 32];
  assign destReg   = wb_in[OFF_DESTREG  +: 5];
  assign aluResult = wb_in[OFF_ALU      +: 32];
  assign dataOut   = wb_in[OFF_DATAOUT  +: 32];
  assign pcToReg   = wb_in[OFF_PCTOREG];
  assign regWrite  = wb_in[OFF_REGWRITE];
  assign memToReg  = wb_in[OFF_MEMTOREG];
  assign loadSign  = wb_in[OFF_LOADSIGN];
  assign dSize     = wb_in[OFF_DSIZE    +: 2];

  // Byte offset is the two least significant address bits of aluResult.
  load_align uLoadAlign (
    .dataOut     (dataOut),
    .byteOffset  (aluResult[1:0]),
    .dSize       (dSize),
    .loadSign    (loadSign),
    .alignedData (alignedData)
  );

  // Writeback select: link PC beats load data, load data beats ALU result.
  always_comb begin
    wbValue = aluResult;
    if (pcToReg) begin
      wbValue = nextPc;
    end else if (memToReg) begin
      wbValue = alignedData;
    end
  end

  // Writes to r0 are suppressed here so the forwarding unit never sees them.
  assign writeEn = regWrite && (destReg != REG_ZERO);

  assign wb_we   = writeEn;
  assign wb_reg  = destReg;
  assign wb_data = wbValue;

  // Register array. Entry 0 is cleared and never written, so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regFile[i] <= '0;
      end
    end else if (writeEn) begin
      regFile[destReg] <= wbValue;
    end
  end

  // Read with write-through bypass so decode sees this cycle's writeback
  // without waiting for the edge.
  function automatic logic [31:0] readPort(input logic [4:0] addr);
    if (addr == REG_ZERO) begin
      return '0;
    end else if (writeEn && (addr == destReg)) begin
      return wbValue;
    end else begin
      return regFile[addr];
    end
  endfunction

  always_comb begin
    rs1_data = readPort(rs1_addr);
    rs2_data = readPort(rs2_addr);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile: a table of single-cycle vectors with
//   hand-computed results, plus hand-written reset sequences.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic         clk;
  logic         reset;
  logic [0:106] wbIn;
  logic [0:4]   rs1Addr;
  logic [0:4]   rs2Addr;
  logic [0:31]  rs1Data;
  logic [0:31]  rs2Data;
  logic         wbWe;
  logic [0:4]   wbReg;
  logic [0:31]  wbData;

  int totalChecks = 0;
  int passChecks  = 0;

  typedef struct {
    logic [4:0]  destReg;
    logic        regWrite;
    logic        pcToReg;
    logic        memToReg;
    logic        loadSign;
    logic [1:0]  dSize;
    logic [31:0] nextPc;
    logic [31:0] aluResult;
    logic [31:0] dataOut;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        expWe;
    logic [31:0] expData;
    logic [31:0] expRs1;
    logic [31:0] expRs2;
  } vecT;

  vecT vecs[$];

  localparam logic [31:0] LD = 32'h80FF7F01;

  wb_regfile dut (
    .clk      (clk),
    .reset    (reset),
    .wb_in    (wbIn),
    .rs1_addr (rs1Addr),
    .rs2_addr (rs2Addr),
    .rs1_data (rs1Data),
    .rs2_data (rs2Data),
    .wb_we    (wbWe),
    .wb_reg   (wbReg),
    .wb_data  (wbData)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vecT mkVec(
    input logic [4:0] destReg, input logic regWrite, input logic pcToReg,
    input logic memToReg, input logic loadSign, input logic [1:0] dSize,
    input logic [31:0] nextPc, input logic [31:0] aluResult,
    input logic [31:0] dataOut, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic expWe, input logic [31:0] expData,
    input logic [31:0] expRs1, input logic [31:0] expRs2);
    vecT v;
    v.destReg = destReg;   v.regWrite = regWrite; v.pcToReg = pcToReg;
    v.memToReg = memToReg; v.loadSign = loadSign; v.dSize = dSize;
    v.nextPc = nextPc;     v.aluResult = aluResult; v.dataOut = dataOut;
    v.rs1 = rs1;           v.rs2 = rs2;           v.expWe = expWe;
    v.expData = expData;   v.expRs1 = expRs1;     v.expRs2 = expRs2;
    return v;
  endfunction

  // Drive one bundle and the two read addresses (bundle packed MSB-first).
  task automatic applyStimulus(input vecT v);
    wbIn = {v.nextPc, v.destReg, v.aluResult, v.dataOut, v.pcToReg,
            v.regWrite, v.memToReg, v.loadSign, v.dSize};
    rs1Addr = v.rs1;
    rs2Addr = v.rs2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Bubble with no write, reading the two given registers.
  function automatic vecT readVec(input logic [4:0] a, input logic [4:0] b);
    return mkVec(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, a, b,
                 1'b0, '0, '0, '0);
  endfunction

  function automatic vecT writeVec(input logic [4:0] d, input logic [31:0] val,
                                   input logic [4:0] a, input logic [4:0] b);
    return mkVec(d, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, val, '0, a, b,
                 1'b0, '0, '0, '0);
  endfunction

  initial begin
    // Directed vectors: each is driven after a falling edge, checked before
    // the next rising edge, then committed by that edge.
    vecs.push_back(mkVec(7,  1,0,0,0,2'd0, 0, 32'h12345678, 0,  7, 0,  1, 32'h12345678, 32'h12345678, 0));
    vecs.push_back(mkVec(3,  0,0,0,0,2'd0, 0, 32'h0000AAAA, 0,  7, 3,  0, 32'h0000AAAA, 32'h12345678, 0));
    vecs.push_back(mkVec(0,  1,0,0,0,2'd0, 0, 32'h00000055, 0,  0, 7,  0, 32'h00000055, 0, 32'h12345678));
    vecs.push_back(mkVec(10, 1,0,1,1,2'd0, 0, 32'h00001000, LD, 10, 0, 1, 32'hFFFFFF80, 32'hFFFFFF80, 0));
    vecs.push_back(mkVec(11, 1,0,1,0,2'd0, 0, 32'h00001002, LD, 11, 10, 1, 32'h0000007F, 32'h0000007F, 32'hFFFFFF80));
    vecs.push_back(mkVec(12, 1,0,1,1,2'd1, 0, 32'h00001002, LD, 12, 11, 1, 32'h00007F01, 32'h00007F01, 32'h0000007F));
    vecs.push_back(mkVec(13, 1,0,1,0,2'd1, 0, 32'h00001000, LD, 13, 12, 1, 32'h000080FF, 32'h000080FF, 32'h00007F01));
    vecs.push_back(mkVec(14, 1,0,1,1,2'd0, 0, 32'h00001001, LD, 14, 13, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000080FF));
    vecs.push_back(mkVec(15, 1,0,1,1,2'd1, 0, 32'h00001003, LD, 15, 0,  1, 32'h00007F01, 32'h00007F01, 0));
    vecs.push_back(mkVec(16, 1,0,1,1,2'd2, 0, 32'h00001000, LD, 16, 0,  1, LD, LD, 0));
    vecs.push_back(mkVec(17, 1,0,1,0,2'd3, 0, 32'h00001000, LD, 17, 16, 1, LD, LD, LD));
    vecs.push_back(mkVec(20, 1,0,0,0,2'd0, 0, 32'h0000A5A5, LD, 20, 17, 1, 32'h0000A5A5, 32'h0000A5A5, LD));
    vecs.push_back(mkVec(31, 1,1,1,0,2'd0, 32'h00000104, 32'h00001000, LD, 31, 10, 1, 32'h00000104, 32'h00000104, 32'hFFFFFF80));
    vecs.push_back(mkVec(0,  0,0,0,0,2'd0, 0, 0, 0, 31, 14, 0, 0, 32'h00000104, 32'hFFFFFFFF));
    vecs.push_back(mkVec(4,  0,0,0,0,2'd0, 0, 32'h00000999, 0, 4, 11, 0, 32'h00000999, 0, 32'h0000007F));
    vecs.push_back(mkVec(4,  1,0,0,0,2'd0, 0, 32'h00000001, 0, 4, 4,  1, 32'h00000001, 32'h00000001, 32'h00000001));
    vecs.push_back(mkVec(4,  1,0,0,0,2'd0, 0, 32'h00000002, 0, 4, 4,  1, 32'h00000002, 32'h00000002, 32'h00000002));
    vecs.push_back(mkVec(0,  0,0,0,0,2'd0, 0, 0, 0, 4, 15, 0, 0, 32'h00000002, 32'h00007F01));
    vecs.push_back(mkVec(0,  0,0,0,0,2'd0, 0, 0, 0, 17, 7, 0, 0, LD, 32'h12345678));
    vecs.push_back(mkVec(0,  0,0,0,0,2'd0, 0, 0, 0, 20, 13, 0, 0, 32'h0000A5A5, 32'h000080FF));

    // Power-on reset: array reads zero, a bubble gives no write enable.
    reset = 1'b0;
    applyStimulus(readVec(5'd7, 5'd31));
    #1;
    checkOutput("resetWe",  {31'd0, wbWe}, 32'd0);
    checkOutput("resetRs1", rs1Data, 32'd0);
    checkOutput("resetRs2", rs2Data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven section
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d.we", i),   {31'd0, wbWe}, {31'd0, vecs[i].expWe});
      checkOutput($sformatf("v%0d.reg", i),  {27'd0, wbReg}, {27'd0, vecs[i].destReg});
      checkOutput($sformatf("v%0d.data", i), wbData, vecs[i].expData);
      checkOutput($sformatf("v%0d.rs1", i),  rs1Data, vecs[i].expRs1);
      checkOutput($sformatf("v%0d.rs2", i),  rs2Data, vecs[i].expRs2);
    end

    // Reset asserted between edges while a write is pending: r6 must not
    // be committed, r7 clears at once, bypass still follows the bundle.
    @(negedge clk);
    applyStimulus(writeVec(5'd6, 32'hCAFEF00D, 5'd6, 5'd7));
    #1;
    checkOutput("midBypassPre", rs1Data, 32'hCAFEF00D);
    checkOutput("midR7Pre",     rs2Data, 32'h12345678);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midR7Cleared",  rs2Data, 32'd0);
    checkOutput("midBypassRst",  rs1Data, 32'hCAFEF00D);
    checkOutput("midWeRst",      {31'd0, wbWe}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(readVec(5'd6, 5'd31));
    #2;
    checkOutput("midR6Lost",  rs1Data, 32'd0);
    checkOutput("midR31Zero", rs2Data, 32'd0);

    // First write after release commits on the next edge.
    @(negedge clk);
    applyStimulus(writeVec(5'd9, 32'h00000077, 5'd0, 5'd0));
    @(negedge clk);
    applyStimulus(readVec(5'd9, 5'd0));
    #2;
    checkOutput("postRstWrite", rs1Data, 32'h00000077);

    // Reset pulse clears a committed register.
    @(negedge clk);
    applyStimulus(writeVec(5'd5, 32'hDEADBEEF, 5'd0, 5'd0));
    @(negedge clk);
    applyStimulus(readVec(5'd5, 5'd9));
    #2;
    checkOutput("r5Written", rs1Data, 32'hDEADBEEF);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("r5ClearedInRst", rs1Data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    checkOutput("r5AfterRst", rs1Data, 32'd0);
    checkOutput("r9AfterRst", rs2Data, 32'd0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and integer register file of the five-stage pipeline. Consumes the 107-bit MEM/WB bundle, selects the writeback value (link PC, aligned/extended load data, or ALU result), and commits it to a 32 x 32-bit register file. It also serves the decode stage's two read ports with same-cycle write-through bypass. Register r0 is hardwired to zero.

## Interface
- `WIDTH`, 107: MEM/WB bundle width; the field map below is fixed for 107.
- `NREG`, 32: number of architectural registers; 5-bit register index.

- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `wb_in`  in  [0:WIDTH-1]: MEM/WB bundle (bit 0 = MSB). Field map:
  - nextPC [0:31]
  - destReg [32:36]
  - aluResult [37:68]
  - dataOut [69:100]
  - PCtoReg [101]
  - RegWrite [102]
  - MemToReg [103]
  - loadSign [104]
  - DSize [105:106]
- `rs1_addr`  in  [0:4]: decode read port A index.
- `rs2_addr`  in  [0:4]: decode read port B index.
- `rs1_data`  out  [0:31]: read port A data.
- `rs2_data`  out  [0:31]: read port B data.
- `wb_we`  out  1: effective write enable, used by the forwarding unit.
- `wb_reg`  out  [0:4]: destination index being written.
- `wb_data`  out  [0:31]: value being written.

## Operation
- Writeback select priority:
  - PCtoReg=1: nextPC.
  - else MemToReg=1: aligned load value.
  - else: aluResult.
- Load alignment:
  - dataOut is the full big-endian word at the word-aligned address.
  - Byte offset is aluResult[67:68]; offset 0 selects bits [0:7].
  - DSize 00 = byte: selected byte.
  - DSize 01 = halfword: aluResult[67]=0 selects [0:15], =1 selects [16:31]; aluResult[68] is ignored.
  - DSize 10 or 11 = word: dataOut unchanged.
  - loadSign=1 sign-extends byte and halfword loads; loadSign=0 zero-extends them.
- Effective write enable: wb_we = RegWrite and (destReg != 0).
- `wb_reg` = destReg and `wb_data` = selected value, driven regardless of wb_we.
- Register array: on a rising edge with wb_we=1, reg[destReg] <= wb_data. Index 0 is never stored and always reads 0.
- Read ports are combinational:
  - rsN_addr == 0: output 0.
  - else wb_we=1 and rsN_addr == destReg: output wb_data (write-through bypass).
  - else: output reg[rsN_addr].
- A flushed or bubble bundle (RegWrite=0) writes nothing; other fields are don't-care.

## Timing
- Reset asserted (reset=0): all registers clear to 0 immediately, asynchronously. While reset is held:
  - rs1_data/rs2_data read 0, except for same-cycle bypass data.
  - wb_we, wb_reg and wb_data still track wb_in combinationally.
  - No writes are committed.
- Reset deasserted: the first write can commit on the next rising edge.
- Reset asserted between edges mid-operation: any write not yet committed is lost.
- Write latency: a value is visible through the bypass in the same cycle, and from the array after one rising edge.
- Two writes to the same index on consecutive edges: the later value wins; the bypass always shows the current bundle's value.
- rs1_addr == rs2_addr == destReg: both ports return wb_data.
- PCtoReg=1 with MemToReg=1: nextPC is written (priority rule).
- No handshake: the block accepts one bundle per cycle, and a stall is expressed upstream by holding RegWrite=0.

## Structure
- Shared pipeline package holds:
  - field offset constants for the MEM/WB bundle;
  - DSize encoding constants (DSIZE_BYTE=00, DSIZE_HALF=01, DSIZE_WORD=10);
  - REG_ZERO=5'd0.
- One sub-module, `load_align`: combinational. Inputs are dataOut, byte offset, DSize and loadSign; output is the 32-bit aligned value. Instantiated once.
- The top level contains the writeback mux, write-enable logic, register array and read/bypass logic.

## Test plan
- Reset clears the array: write 0xDEADBEEF to r5, pulse reset=0, release, then read r5 -> 0x00000000.
- ALU write with bypass and r0 protection:
  - RegWrite=1, destReg=7, aluResult=0x12345678, rs1=7 -> rs1_data=0x12345678 in the same cycle and after the edge.
  - destReg=0 -> wb_we=0, r0 reads 0.
- Load byte/halfword extension with dataOut=0x80FF7F01:
  - byte, offset 0, signed -> 0xFFFFFF80.
  - byte, offset 2, unsigned -> 0x0000007F.
  - halfword, offset 2, signed -> 0x00007F01.
  - halfword, offset 0, unsigned -> 0x000080FF.
- Link write: PCtoReg=1, MemToReg=1, nextPC=0x00000104, destReg=31 -> r31=0x00000104.
- Bubble and back-to-back writes:
  - RegWrite=0 with destReg=4 -> r4 unchanged.
  - Consecutive writes of 0x1 then 0x2 to r4 -> r4=0x2.
  - rs1=rs2=4 during the second write -> both ports read 0x2.
- Asynchronous reset mid-cycle: assert reset between edges while RegWrite=1 -> the array reads 0 immediately and the write is not committed.
